uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter with a valid/ready byte interface, a programmable baud divider, and configurable data width and stop-bit count. An upstream producer hands it one word at a time, and it serialises each word onto the `tx` pin LSB-first inside a start/stop frame. It is the drop-in successor to our fixed 8-bit, one-bit-per-clock transmitter for any path that needs real baud rates and back-to-back streaming.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: `clkin` cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; only used when parity is compiled in.

Ports:
- `clkin`  input  1  single clock; all logic on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_data`  input  DATA_BITS  word to send; sampled only on handshake.
- `tx_valid`  input  1  producer has a word.
- `tx_ready`  output  1  block can accept a word; high only in IDLE.
- `tx`  output  1  serial line, idle high; registered output.
- `busy`  output  1  frame in progress (inverse of `tx_ready`).

## Operation
- A handshake occurs when `tx_valid` and `tx_ready` are both high at a `clkin` edge. At that edge the block:
  - latches `tx_data` into a shift register,
  - moves IDLE→START,
  - drives `tx` = 0.
- States and transitions:
  - IDLE (`tx` = 1): go to START on handshake.
  - START (`tx` = 0, 1 bit time): go to DATA.
  - DATA (`tx` = shift_reg[0], DATA_BITS bit times, shift right after each bit): go to PARITY if compiled in, else STOP.
  - PARITY (1 bit time): go to STOP.
  - STOP (`tx` = 1, STOP_BITS bit times): go to IDLE.
- One bit time is CLKS_PER_BIT clocks, timed by a baud counter running 0..CLKS_PER_BIT-1.
  - The counter clears on every state entry and on every data-bit advance.
  - Counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS+1).
- `tx_data` and `tx_valid` are ignored outside IDLE. The latched word is not affected by input changes mid-frame.
- Undefined state encodings go to IDLE with `tx` = 1.
- Reset asserted at any time, including mid-frame:
  - state = IDLE, `tx` = 1, `tx_ready` = 1, `busy` = 0, counters = 0;
  - any partial frame is abandoned with no completion.
- Illegal parameter values are rejected at elaboration (generate-time `$error`).

## Timing
- Reset values: `tx` = 1, `tx_ready` = 1, `busy` = 0.
- Latency: the start bit appears on `tx` at the handshake edge, so there are zero idle cycles before the falling edge.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + P + STOP_BITS), with P = 1 if parity is compiled in, else 0.
- `tx_ready` falls at the handshake edge and rises at the edge that ends the last stop-bit clock.
- When `tx_valid` is held high, handshakes occur exactly F+1 clocks apart. `tx` holds 1 for STOP_BITS × CLKS_PER_BIT + 1 clocks between frames.
- Every bit is held for exactly CLKS_PER_BIT clocks with no jitter.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state is present. The parity bit is the XOR of the latched data bits, inverted when PARITY_ODD = 1, and is sent after the MSB.
- Undefined: there is no PARITY state, DATA goes directly to STOP, and PARITY_ODD is ignored.

## Test plan
- Single byte, CLKS_PER_BIT = 4, DATA_BITS = 8, STOP_BITS = 1, no parity. Send 8'h99 → `tx` bit sequence 0,1,0,0,1,1,0,0,1,1, each held 4 clocks; `tx_ready` low for exactly 40 clocks.
- Back-to-back. Hold `tx_valid` high with 8'hA5 then 8'h3C → second start bit begins 41 clocks after the first; both words decode correctly; the gap is 5 high clocks.
- Parity, with `UART_TX_PARITY_EN`. Send 8'h07: PARITY_ODD = 0 → parity bit 1; PARITY_ODD = 1 → parity bit 0; frame = 44 clocks.
- Width/stop variant, DATA_BITS = 5, STOP_BITS = 2. Send 5'h15 → bits 0,1,0,1,0,1,1,1; F = 32 clocks at CLKS_PER_BIT = 4.
- Reset mid-frame. Assert `rst` during data bit 3 → `tx` = 1 and `tx_ready` = 1 immediately (asynchronous). After release, a new word 8'h55 is framed correctly.
- Input stability. Toggle `tx_data` and `tx_valid` while `busy` = 1 → the transmitted word is unchanged and no extra handshake occurs.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: valid/ready UART transmitter, LSB-first, start/data/[parity]/stop frame.
// Define UART_TX_PARITY_EN to insert a parity bit after the MSB (PARITY_ODD selects odd).
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clkin,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
            $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // idx counts data bits in DATA and stop bits in STOP; it is zero on entry to both.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        bit_done = (cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (tx_valid) begin
                    state_d  = S_START;
                    shift_d  = tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // tx is registered from the next state so the start bit lands on the handshake edge.
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        tx_ready = (state_q == S_IDLE);
        busy     = ~tx_ready;
        tx       = tx_q;
    end

endmodule
